leds_racer_players: RTL
=======================

Name: leds_racer_players

Overview:
N-player input and race-state engine for the LEDs racer game, generalising the fixed four-colour button handling to a parametrised player count. Each player button is synchronised and debounced, and its presses drive a lobby/race/finished state machine. The block keeps the per-player track positions and the winner. Its outputs feed the LED-line frame renderer and the test-point outputs (ready flags, screen code, frame update).

Parameters:
N_PLAYERS, 4, number of player buttons/channels (1..8)
MAX_POS, 109, finish position; position range 0..MAX_POS
DEBOUNCE_CLK_CNT, 65536, consecutive stable cycles required to accept a button level change (>=2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
btn_in  input  N_PLAYERS  raw asynchronous button levels, bit i = player i
start_req  input  1  level; lobby->race, and finished->lobby
positions  output  N_PLAYERS*POS_W  flat bus, player i at [i*POS_W +: POS_W], POS_W=$clog2(MAX_POS+1)
ready_mask  output  N_PLAYERS  player i has joined the race
press_pulse  output  N_PLAYERS  one-cycle debounced press event per player
screen  output  2  0=LOBBY, 1=RACE, 2=FINISHED, 3 never driven
winner_valid  output  1  high in FINISHED
winner_id  output  $clog2(N_PLAYERS) (min 1)  index of winner, valid when winner_valid
update_frame  output  1  one-cycle pulse: renderer must redraw

Behaviour:
- Reset (async assert, sync release): sync flops, stable levels and debounce counters 0; positions 0; ready_mask 0; press_pulse 0; screen LOBBY; winner_valid 0; winner_id 0; update_frame 0.
- Synchroniser: 2 flops per channel. btn_in is never used unsynchronised.
- Debounce per channel:
  - Counter width $clog2(DEBOUNCE_CLK_CNT+1).
  - Counter clears whenever the synced level equals the stable level; otherwise it increments.
  - The stable level flips on the edge where the counter would reach DEBOUNCE_CLK_CNT; the counter clears on that same edge.
  - A glitch shorter than DEBOUNCE_CLK_CNT cycles produces no change.
- press_pulse[i]: registered, high exactly one cycle, in the cycle after stable[i] rises 0->1. Releases generate nothing.
- Latency: btn_in rise to press_pulse high = 2 + DEBOUNCE_CLK_CNT + 1 cycles.
- FSM actions, evaluated on press_pulse (the cycle it is high):
  - LOBBY:
    - press toggles ready_mask[i].
    - start_req high with ready_mask != 0 -> RACE; positions already 0.
    - start_req with ready_mask == 0 is ignored.
    - Press and start_req in the same cycle: the toggle is applied and the transition uses the pre-toggle mask.
  - RACE:
    - press by a ready player: position += 1, saturating at MAX_POS.
    - press by a non-ready player is ignored.
    - start_req is ignored.
    - If any position reaches MAX_POS on an edge, the next state is FINISHED. winner_id = lowest index reaching MAX_POS on that edge (simultaneous finish -> lowest index wins). winner_valid rises.
  - FINISHED:
    - positions, winner frozen; presses ignored (press_pulse still emitted).
    - start_req -> LOBBY; clears positions, ready_mask, winner_valid, winner_id in the same edge.
- update_frame: registered, high one cycle after any edge that changes positions, ready_mask or screen. Never high for two consecutive cycles unless two consecutive edges change state. Back-to-back changes give back-to-back pulses.
- Arithmetic: positions unsigned POS_W bits; increment never wraps.
- Reset mid-operation: immediate return to the reset values in any state, including during a debounce count.

Decomposition:
- Package leds_racer_pkg:
  - screen encoding constants SCREEN_LOBBY/RACE/FINISHED;
  - width helper function (clog2 with min 1).
- Sub-module leds_racer_debounce, one channel: synchroniser + counter + stable level + press pulse; parameter DEBOUNCE_CLK_CNT. Instantiated N_PLAYERS times via generate.
- Top holds the FSM, position registers, winner logic and update_frame.

Test Plan:
Bench configuration: N_PLAYERS=4, MAX_POS=5, DEBOUNCE_CLK_CNT=4.
1. btn_in[0] high 3 cycles then low -> press_pulse stays 0000, no update_frame. btn_in[0] held high -> press_pulse[0] high exactly at cycle 7 after the rise, for one cycle.
2. LOBBY: press p0, p2, then start_req -> ready_mask=0101, screen=1. Each toggle and the state change give one update_frame pulse. start_req with ready_mask=0000 -> screen stays 0.
3. RACE: p2 presses 5 times -> positions[2] 1..5, screen=2, winner_valid=1, winner_id=2. A sixth press -> positions unchanged, no update_frame.
4. Ready p1,p3; bring both to 4; final presses debounced in the same cycle -> both positions=5, winner_id=1.
5. p1 not ready, presses during RACE -> position[1] stays 0, press_pulse[1] still pulses. start_req in FINISHED -> screen=0, positions all 0, ready_mask=0000.
6. reset asserted mid-RACE with positions {3,0,2,0} and a debounce in progress -> all outputs immediately at reset values. After release, the held button needs a full 4-cycle debounce before press_pulse.

Source files
------------

// File: rtl/leds_racer_pkg.sv
// Shared definitions for the LEDs racer player engine: screen codes, FSM states
// and a width helper.
package leds_racer_pkg;

    localparam logic [1:0] SCREEN_LOBBY    = 2'd0;
    localparam logic [1:0] SCREEN_RACE     = 2'd1;
    localparam logic [1:0] SCREEN_FINISHED = 2'd2;

    // State codes double as the screen code, so the screen output is the state register.
    typedef enum logic [1:0] {
        ST_LOBBY    = SCREEN_LOBBY,
        ST_RACE     = SCREEN_RACE,
        ST_FINISHED = SCREEN_FINISHED
    } state_e;

    function automatic int clog2_min1(input int value);
        if (value <= 1) begin
            return 1;
        end else begin
            return $clog2(value);
        end
    endfunction

endpackage

// File: rtl/leds_racer_debounce.sv
// One button channel: two-flop synchroniser, stability counter, debounced level
// and a one-cycle press event on each accepted 0->1 transition.
module leds_racer_debounce #(
    parameter int  DEBOUNCE_CLK_CNT = 65536,
    localparam int CNT_W            = $clog2(DEBOUNCE_CLK_CNT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic press_pulse
);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic             stable_prev_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count consecutive cycles of disagreement; accept the new level on the final count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CLK_CNT - 1)) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Synchroniser, debounce state and registered press detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            cnt_q         <= '0;
            press_q       <= 1'b0;
        end else begin
            sync1_q       <= btn_in;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            cnt_q         <= cnt_d;
            press_q       <= stable_q & ~stable_prev_q;
        end
    end

    assign press_pulse = press_q;

endmodule

// File: rtl/leds_racer_players.sv
// N-player race engine: debounced buttons drive a lobby/race/finished FSM that
// tracks per-player positions, the winner and a redraw request.
module leds_racer_players
    import leds_racer_pkg::*;
#(
    parameter int  N_PLAYERS        = 4,
    parameter int  MAX_POS          = 109,
    parameter int  DEBOUNCE_CLK_CNT = 65536,
    localparam int POS_W            = $clog2(MAX_POS + 1),
    localparam int WID_W            = clog2_min1(N_PLAYERS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_PLAYERS-1:0]         btn_in,
    input  logic                         start_req,
    output logic [N_PLAYERS*POS_W-1:0]   positions,
    output logic [N_PLAYERS-1:0]         ready_mask,
    output logic [N_PLAYERS-1:0]         press_pulse,
    output logic [1:0]                   screen,
    output logic                         winner_valid,
    output logic [WID_W-1:0]             winner_id,
    output logic                         update_frame
);

    logic [N_PLAYERS-1:0]            press_s;
    state_e                          state_q;
    state_e                          state_d;
    logic [N_PLAYERS-1:0][POS_W-1:0] pos_q;
    logic [N_PLAYERS-1:0][POS_W-1:0] pos_d;
    logic [N_PLAYERS-1:0]            ready_q;
    logic [N_PLAYERS-1:0]            ready_d;
    logic                            winner_valid_q;
    logic                            winner_valid_d;
    logic [WID_W-1:0]                winner_id_q;
    logic [WID_W-1:0]                winner_id_d;
    logic                            update_q;
    logic                            update_d;
    logic                            finish_s;

    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_btn
        leds_racer_debounce #(
            .DEBOUNCE_CLK_CNT(DEBOUNCE_CLK_CNT)
        ) u_debounce (
            .clk        (clk),
            .reset      (reset),
            .btn_in     (btn_in[g]),
            .press_pulse(press_s[g])
        );
    end

    // Next-state logic for the game FSM, positions, winner and redraw request.
    always_comb begin
        state_d        = state_q;
        pos_d          = pos_q;
        ready_d        = ready_q;
        winner_valid_d = winner_valid_q;
        winner_id_d    = winner_id_q;
        finish_s       = 1'b0;
        case (state_q)
            ST_LOBBY: begin
                ready_d = ready_q ^ press_s;
                // The pre-toggle mask decides whether a race can start.
                if (start_req && (ready_q != '0)) begin
                    state_d = ST_RACE;
                end else begin
                    state_d = ST_LOBBY;
                end
            end
            ST_RACE: begin
                for (int i = 0; i < N_PLAYERS; i++) begin
                    if (press_s[i] && ready_q[i] && (pos_q[i] != POS_W'(MAX_POS))) begin
                        pos_d[i] = pos_q[i] + POS_W'(1);
                    end else begin
                        pos_d[i] = pos_q[i];
                    end
                end
                // Scan downward so the lowest finishing index is the one kept.
                for (int i = N_PLAYERS - 1; i >= 0; i--) begin
                    if (pos_d[i] == POS_W'(MAX_POS)) begin
                        finish_s    = 1'b1;
                        winner_id_d = WID_W'(i);
                    end else begin
                        finish_s    = finish_s;
                    end
                end
                if (finish_s) begin
                    state_d        = ST_FINISHED;
                    winner_valid_d = 1'b1;
                end else begin
                    state_d        = ST_RACE;
                end
            end
            ST_FINISHED: begin
                if (start_req) begin
                    state_d        = ST_LOBBY;
                    pos_d          = '0;
                    ready_d        = '0;
                    winner_valid_d = 1'b0;
                    winner_id_d    = '0;
                end else begin
                    state_d        = ST_FINISHED;
                end
            end
            default: begin
                state_d = ST_LOBBY;
            end
        endcase
        update_d = (pos_d != pos_q) || (ready_d != ready_q) || (state_d != state_q);
    end

    // Game state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_LOBBY;
            pos_q          <= '0;
            ready_q        <= '0;
            winner_valid_q <= 1'b0;
            winner_id_q    <= '0;
            update_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            pos_q          <= pos_d;
            ready_q        <= ready_d;
            winner_valid_q <= winner_valid_d;
            winner_id_q    <= winner_id_d;
            update_q       <= update_d;
        end
    end

    assign positions    = pos_q;
    assign ready_mask   = ready_q;
    assign press_pulse  = press_s;
    assign screen       = state_q;
    assign winner_valid = winner_valid_q;
    assign winner_id    = winner_id_q;
    assign update_frame = update_q;

endmodule
